// File: rtl/branch_redirect_unit.sv
// Branch/jump resolution at the EX/MEM boundary: redirect, flush, link and
// squash control for the five-stage pipeline, plus branch statistics.
module branch_redirect_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_branchType,
  input  logic [31:0] ex_pc_4,
  input  logic [31:0] ex_rsData,
  input  logic [31:0] ex_rtData,
  input  logic [31:0] ex_immediate,
  input  logic [25:0] ex_jumpIndex,
  output logic        mem_shouldBranch,
  output logic [31:0] mem_branchPc,
  output logic        mem_linkWrite,
  output logic [31:0] mem_linkAddr,
  output logic        mem_misaligned,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] branchCount,
  output logic [31:0] takenCount
);

  localparam logic [2:0] BT_BEQ = 3'b001;
  localparam logic [2:0] BT_BNE = 3'b010;
  localparam logic [2:0] BT_J   = 3'b011;
  localparam logic [2:0] BT_JR  = 3'b100;
  localparam logic [2:0] BT_JAL = 3'b101;

  // REDIRECT is the captured-valid-and-taken half of the EX/MEM register;
  // RUN covers bubbles, not-taken branches and non-branch instructions.
  typedef enum logic {RUN, REDIRECT} state_t;
  state_t state;

  logic        is_branch;
  logic        cond;
  logic        is_jal;
  logic        misaligned;
  logic [31:0] imm_shift;
  logic [31:0] target;
  logic        squash;
  logic        capture;
  logic        taken;

  assign imm_shift = ex_immediate << 2;

  always_comb begin
    is_branch  = 1'b0;
    cond       = 1'b0;
    is_jal     = 1'b0;
    misaligned = 1'b0;
    target     = 32'h0;
    case (ex_branchType)
      BT_BEQ: begin
        is_branch = 1'b1;
        cond      = (ex_rsData == ex_rtData);
        target    = ex_pc_4 + imm_shift;
      end
      BT_BNE: begin
        is_branch = 1'b1;
        cond      = (ex_rsData != ex_rtData);
        target    = ex_pc_4 + imm_shift;
      end
      BT_J: begin
        is_branch = 1'b1;
        cond      = 1'b1;
        target    = {ex_pc_4[31:28], ex_jumpIndex, 2'b00};
      end
      BT_JR: begin
        is_branch  = 1'b1;
        cond       = 1'b1;
        misaligned = |ex_rsData[1:0];
        target     = {ex_rsData[31:2], 2'b00};
      end
      BT_JAL: begin
        is_branch = 1'b1;
        cond      = 1'b1;
        is_jal    = 1'b1;
        target    = {ex_pc_4[31:28], ex_jumpIndex, 2'b00};
      end
      default: begin
        is_branch = 1'b0;
      end
    endcase
  end

  // The instruction in EX while a redirect is out is on the wrong path.
  assign squash  = (state == REDIRECT);
  assign capture = ex_valid & ~squash & is_branch;
  assign taken   = capture & cond;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= RUN;
      mem_shouldBranch <= 1'b0;
      mem_branchPc     <= 32'h0;
      mem_linkWrite    <= 1'b0;
      mem_linkAddr     <= 32'h0;
      mem_misaligned   <= 1'b0;
      flush_if_id      <= 1'b0;
      flush_id_ex      <= 1'b0;
      branchCount      <= 32'h0;
      takenCount       <= 32'h0;
    end else begin
      mem_branchPc <= target;
      mem_linkAddr <= ex_pc_4;
      case (state)
        RUN: begin
          if (taken) begin
            state            <= REDIRECT;
            mem_shouldBranch <= 1'b1;
            flush_if_id      <= 1'b1;
            flush_id_ex      <= 1'b1;
            mem_linkWrite    <= is_jal;
            mem_misaligned   <= misaligned;
          end else begin
            state            <= RUN;
            mem_shouldBranch <= 1'b0;
            flush_if_id      <= 1'b0;
            flush_id_ex      <= 1'b0;
            mem_linkWrite    <= 1'b0;
            mem_misaligned   <= 1'b0;
          end
        end
        REDIRECT: begin
          state            <= RUN;
          mem_shouldBranch <= 1'b0;
          flush_if_id      <= 1'b0;
          flush_id_ex      <= 1'b0;
          mem_linkWrite    <= 1'b0;
          mem_misaligned   <= 1'b0;
        end
        default: begin
          state            <= RUN;
          mem_shouldBranch <= 1'b0;
          flush_if_id      <= 1'b0;
          flush_id_ex      <= 1'b0;
          mem_linkWrite    <= 1'b0;
          mem_misaligned   <= 1'b0;
        end
      endcase
      if (capture) branchCount <= branchCount + 32'd1;
      if (taken)   takenCount  <= takenCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: redirect timing, flushes, squash,
// link, misaligned jr, counters with wrap, and asynchronous reset.
module tb_branch_redirect_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_branchType;
  logic [31:0] ex_pc_4, ex_rsData, ex_rtData, ex_immediate;
  logic [25:0] ex_jumpIndex;
  logic        mem_shouldBranch, mem_linkWrite, mem_misaligned;
  logic        flush_if_id, flush_id_ex;
  logic [31:0] mem_branchPc, mem_linkAddr, branchCount, takenCount;

  int tests = 0;
  int failed = 0;

  branch_redirect_unit dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_branchType(ex_branchType),
    .ex_pc_4(ex_pc_4), .ex_rsData(ex_rsData), .ex_rtData(ex_rtData),
    .ex_immediate(ex_immediate), .ex_jumpIndex(ex_jumpIndex),
    .mem_shouldBranch(mem_shouldBranch), .mem_branchPc(mem_branchPc),
    .mem_linkWrite(mem_linkWrite), .mem_linkAddr(mem_linkAddr),
    .mem_misaligned(mem_misaligned), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .branchCount(branchCount), .takenCount(takenCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] bt, input logic [31:0] pc4,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [25:0] idx);
    ex_valid = v; ex_branchType = bt; ex_pc_4 = pc4; ex_rsData = rs;
    ex_rtData = rt; ex_immediate = imm; ex_jumpIndex = idx;
  endtask

  task automatic bubble();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 26'h0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bubble();
    reset = 1'b1;
    #12;
    chk("rst_sb", {31'b0, mem_shouldBranch}, 32'h0);
    chk("rst_flush", {30'b0, flush_if_id, flush_id_ex}, 32'h0);
    chk("rst_pc", mem_branchPc, 32'h0);
    chk("rst_bc", branchCount, 32'h0);
    chk("rst_tc", takenCount, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("idle_sb", {31'b0, mem_shouldBranch}, 32'h0);

    // beq taken, backward target
    drive(1'b1, 3'b001, 32'h100, 32'd5, 32'd5, 32'hFFFF_FFFC, 26'h0);
    tick();
    chk("beq_sb", {31'b0, mem_shouldBranch}, 32'h1);
    chk("beq_pc", mem_branchPc, 32'h0000_00F0);
    chk("beq_flush", {30'b0, flush_if_id, flush_id_ex}, 32'h3);
    chk("beq_link", {31'b0, mem_linkWrite}, 32'h0);
    chk("beq_bc", branchCount, 32'd1);
    chk("beq_tc", takenCount, 32'd1);
    bubble();
    tick();
    chk("beq_sb_drop", {31'b0, mem_shouldBranch}, 32'h0);
    chk("beq_flush_drop", {30'b0, flush_if_id, flush_id_ex}, 32'h0);

    // bne not taken
    drive(1'b1, 3'b010, 32'h200, 32'd7, 32'd7, 32'h4, 26'h0);
    tick();
    chk("bne_sb", {31'b0, mem_shouldBranch}, 32'h0);
    chk("bne_flush", {30'b0, flush_if_id, flush_id_ex}, 32'h0);
    chk("bne_bc", branchCount, 32'd2);
    chk("bne_tc", takenCount, 32'd1);

    // jal followed by a valid j that must be squashed
    drive(1'b1, 3'b101, 32'h8000_0010, 32'h0, 32'h0, 32'h0, 26'h000_0040);
    tick();
    chk("jal_sb", {31'b0, mem_shouldBranch}, 32'h1);
    chk("jal_pc", mem_branchPc, 32'h8000_0100);
    chk("jal_lw", {31'b0, mem_linkWrite}, 32'h1);
    chk("jal_la", mem_linkAddr, 32'h8000_0010);
    chk("jal_bc", branchCount, 32'd3);
    chk("jal_tc", takenCount, 32'd2);
    drive(1'b1, 3'b011, 32'h8000_0014, 32'h0, 32'h0, 32'h0, 26'h000_0123);
    tick();
    chk("sq_sb", {31'b0, mem_shouldBranch}, 32'h0);
    chk("sq_lw", {31'b0, mem_linkWrite}, 32'h0);
    chk("sq_bc", branchCount, 32'd3);
    chk("sq_tc", takenCount, 32'd2);
    bubble();
    tick();
    chk("sq_after_sb", {31'b0, mem_shouldBranch}, 32'h0);

    // misaligned jr
    drive(1'b1, 3'b100, 32'h300, 32'h0040_0007, 32'h0, 32'h0, 26'h0);
    tick();
    chk("jr_sb", {31'b0, mem_shouldBranch}, 32'h1);
    chk("jr_pc", mem_branchPc, 32'h0040_0004);
    chk("jr_mis", {31'b0, mem_misaligned}, 32'h1);
    bubble();
    tick();
    chk("jr_mis_drop", {31'b0, mem_misaligned}, 32'h0);
    chk("jr_bc", branchCount, 32'd4);
    chk("jr_tc", takenCount, 32'd3);

    // bubble carrying j type is ignored
    drive(1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 32'h0, 26'h55);
    tick();
    chk("bub_sb", {31'b0, mem_shouldBranch}, 32'h0);
    chk("bub_bc", branchCount, 32'd4);
    chk("bub_tc", takenCount, 32'd3);

    // type 110 treated as none
    drive(1'b1, 3'b110, 32'h400, 32'h0, 32'h0, 32'h0, 26'h55);
    tick();
    chk("t6_sb", {31'b0, mem_shouldBranch}, 32'h0);
    chk("t6_bc", branchCount, 32'd4);

    // not-taken beq then taken bne back to back
    drive(1'b1, 3'b001, 32'h500, 32'd1, 32'd2, 32'h8, 26'h0);
    tick();
    chk("b2b_a_sb", {31'b0, mem_shouldBranch}, 32'h0);
    chk("b2b_a_bc", branchCount, 32'd5);
    drive(1'b1, 3'b010, 32'h504, 32'd1, 32'd2, 32'h8, 26'h0);
    tick();
    chk("b2b_b_sb", {31'b0, mem_shouldBranch}, 32'h1);
    chk("b2b_b_pc", mem_branchPc, 32'h0000_0524);
    chk("b2b_b_bc", branchCount, 32'd6);
    chk("b2b_b_tc", takenCount, 32'd4);
    bubble();
    tick();

    // takenCount wrap
    force dut.takenCount = 32'hFFFF_FFFF;
    #1;
    release dut.takenCount;
    drive(1'b1, 3'b011, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 26'h10);
    tick();
    chk("wrap0_tc", takenCount, 32'h0000_0000);
    chk("wrap0_pc", mem_branchPc, 32'h1000_0040);
    bubble();
    tick();
    drive(1'b1, 3'b011, 32'h1000_0000, 32'h0, 32'h0, 32'h0, 26'h20);
    tick();
    chk("wrap1_tc", takenCount, 32'h0000_0001);
    chk("wrap1_bc", branchCount, 32'd8);
    bubble();
    tick();

    // async reset during REDIRECT
    drive(1'b1, 3'b011, 32'h0, 32'h0, 32'h0, 32'h0, 26'h30);
    tick();
    chk("ar_pre_sb", {31'b0, mem_shouldBranch}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_sb", {31'b0, mem_shouldBranch}, 32'h0);
    chk("ar_flush", {30'b0, flush_if_id, flush_id_ex}, 32'h0);
    chk("ar_bc", branchCount, 32'h0);
    chk("ar_tc", takenCount, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 3'b001, 32'h100, 32'd9, 32'd9, 32'h1, 26'h0);
    tick();
    chk("post_sb", {31'b0, mem_shouldBranch}, 32'h1);
    chk("post_pc", mem_branchPc, 32'h0000_0104);
    chk("post_bc", branchCount, 32'd1);
    chk("post_tc", takenCount, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Resolves branches and jumps at the EX/MEM boundary of the five-stage pipeline. It drives the redirect pair `mem_shouldBranch` / `mem_branchPc` into the fetch stage and the flush strobes for the younger pipeline registers. It also holds the branch half of the EX/MEM register, squashes the wrong-path instruction behind a taken branch, and keeps taken/resolved statistics counters.

## Interface
- No parameters.
- `clock`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ex_valid`  in  1  EX-stage instruction is real (not a bubble).
- `ex_branchType`  in  3  000 none, 001 beq, 010 bne, 011 j, 100 jr, 101 jal; 110/111 treated as none.
- `ex_pc_4`  in  32  PC+4 of the EX instruction.
- `ex_rsData`  in  32  forwarded rs operand.
- `ex_rtData`  in  32  forwarded rt operand.
- `ex_immediate`  in  32  sign-extended 16-bit immediate.
- `ex_jumpIndex`  in  26  instr[25:0].
- `mem_shouldBranch`  out  1  redirect fetch this cycle; fetch loads `mem_branchPc` at the next edge.
- `mem_branchPc`  out  32  redirect target; low 2 bits always 0.
- `mem_linkWrite`  out  1  MEM instruction is a taken jal; write `mem_linkAddr` to $31.
- `mem_linkAddr`  out  32  registered `ex_pc_4` of the jal.
- `mem_misaligned`  out  1  jr target had nonzero bits [1:0].
- `flush_if_id`  out  1  IF/ID must load a bubble at the next edge.
- `flush_id_ex`  out  1  ID/EX must load a bubble at the next edge.
- `branchCount`  out  32  resolved branch/jump instructions, types 001–101.
- `takenCount`  out  32  taken branch/jump instructions.

## Operation
- **EX-side resolution (combinational):**
  - `taken`: beq when rs==rt; bne when rs!=rt; always for j/jr/jal. Only when `ex_valid` and not squashed.
  - beq/bne target = `ex_pc_4 + (ex_immediate << 2)`, 32-bit modulo; wrap-around is ignored.
  - j/jal target = {`ex_pc_4[31:28]`, `ex_jumpIndex`, 2'b00}.
  - jr target = {`ex_rsData[31:2]`, 2'b00}; misaligned flag = |`ex_rsData[1:0]`.
- **EX/MEM branch register (MEM_VALID, target, link, misaligned):**
  - Captures on every edge.
  - The captured valid is forced to 0 when `mem_shouldBranch` is high during that edge. This is the squash of the wrong-path EX instruction.
- **Two-state control:**
  - RUN: outputs follow the register; a captured taken branch moves the unit to REDIRECT.
  - REDIRECT: lasts exactly one cycle. In this state `mem_shouldBranch=1`, `flush_if_id=1`, `flush_id_ex=1`, and `mem_linkWrite=1` if the instruction is a jal. The unit returns to RUN at the next edge. That edge is squashed, so two consecutive REDIRECT cycles are impossible.
- **Flush coverage:** a taken branch in MEM flushes IF/ID and ID/EX and squashes EX. All three wrong-path instructions die at one edge.
- **Not-taken branches:** no redirect and no flush.
- **Counters:**
  - `branchCount` increments at the edge that captures a valid, unsquashed instruction with type 001–101.
  - `takenCount` increments at the same edge when that instruction is taken.
  - Both wrap at 2^32.
- **Misaligned jr:** still redirects, with the target masked to a word boundary. `mem_misaligned` is high only in that REDIRECT cycle.
- **Bubbles:** `ex_valid=0` is never captured as a branch, counted, or flagged.

## Timing
- **Reset values:** all outputs 0, state RUN, register valid 0.
- **Redirect latency:**
  - Edge N: a taken branch is in EX, and the unit captures it.
  - Cycle N→N+1: `mem_shouldBranch` is high.
  - Edge N+1: fetch loads the target, and the flushes take effect.
  - The target instruction is in IF/ID after edge N+2.
- **Output source:** all outputs are driven from registers only. No combinational path runs from `ex_*` to any output.
- **Reset during REDIRECT:** `mem_shouldBranch` and both flushes drop immediately, and counters clear. The first edge after release captures normally.
- **Back-to-back branches** (A taken, B behind A):
  - B is squashed, so there is one redirect and one count.
  - If A is not taken, B resolves normally in the next cycle.

## Test plan
- Reset: hold `reset`, then release → all outputs 0. Assert `reset` asynchronously mid-REDIRECT → `mem_shouldBranch` falls before the next edge.
- beq, `ex_pc_4`=0x100, imm=0xFFFFFFFC, rs=rt=5:
  - → one-cycle `mem_shouldBranch` with `mem_branchPc`=0x0F0.
  - → both flushes high in that cycle; `branchCount`=1, `takenCount`=1.
- bne with rs=rt → no redirect, no flush; `branchCount`=1, `takenCount`=0.
- jal, `ex_pc_4`=0x80000010, index=0x0000040:
  - → target 0x80000100; `mem_linkWrite`=1 with `mem_linkAddr`=0x80000010.
  - → the next EX instruction (a valid j) is squashed: no second redirect, `branchCount`=1.
- jr with rs=0x00400007 → target 0x00400004 and `mem_misaligned`=1 for exactly one cycle.
- Counter wrap: preload `takenCount` near 0xFFFFFFFF by forcing, then apply two taken j → value 0x00000000 then 0x00000001. Also issue bubbles with `ex_branchType`=011 → no counting.
